// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time from an internal word
// array after WAIT_CYCLES wait states and returns the result over a response handshake.
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              r_write;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];
   logic              w_accept;
   logic              w_access;
   logic              w_err;
   logic [ADDR_W-1:0] w_idx;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_access = (r_state == S_ACCESS);
   assign w_idx    = r_addr[ADDR_W+1:2];
   // Misaligned, or any address bit above the array's byte range is set.
   assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES != 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end else begin
                  w_state_nxt = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = S_ACCESS;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_be    <= req_be;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_access) begin
         r_err   <= w_err;
         r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
      end
   end

   // NOTE: the array is deliberately not reset; its contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_access && r_write && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule
